wb_regfile_pipe: RTL and testbench

- Parametrised, pipelined Wishbone B4 slave register file. It is the next generation of the team's single-outstanding wb_slave.
- Adds byte-select writes, a request FIFO for multiple outstanding requests, configurable wait states, read-only register masking, and address/alignment error reporting.
- Sits behind the Wishbone interconnect and is checked by the same property/monitor environment as wb_slave.

---
 rtl/wb_regfile_pipe.sv | 165 ++++++++++++++++
 tb/tb_wb_regfile_pipe.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_pipe.sv
// Pipelined Wishbone B4 slave register file: request FIFO, byte-lane
// writes, programmable wait states, read-only masking, error terminations.
module wb_regfile_pipe #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int GRANULE = 8,
   parameter int REGISTER_NUM = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int WAIT_STATES = 0,
   parameter logic [REGISTER_NUM-1:0] RO_MASK = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cyc_i,
   input  logic                          stb_i,
   input  logic                          we_i,
   input  logic [ADDR_WIDTH-1:0]         adr_i,
   input  logic [DATA_WIDTH/GRANULE-1:0] sel_i,
   input  logic [DATA_WIDTH-1:0]         dat_i,
   output logic [DATA_WIDTH-1:0]         dat_o,
   output logic                          ack_o,
   output logic                          err_o,
   output logic                          stall_o
);
   localparam int SW = DATA_WIDTH / GRANULE;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = (REGISTER_NUM > 1) ? $clog2(REGISTER_NUM) : 1;
   localparam int WW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam int QW = 1 + ADDR_WIDTH + SW + DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [WW-1:0]         ws_q, ws_d;
   logic [QW-1:0]         cur_q, cur_d;
   logic [QW-1:0]         mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] regs_q [REGISTER_NUM];
   logic [DATA_WIDTH-1:0] regs_d [REGISTER_NUM];

   logic                  cur_we;
   logic [ADDR_WIDTH-1:0] cur_adr;
   logic [ADDR_WIDTH-1:0] idx;
   logic [SW-1:0]         cur_sel;
   logic [DATA_WIDTH-1:0] cur_dat;
   logic [DATA_WIDTH-1:0] rdata;
   logic [RW-1:0]         ri;
   logic                  bad_aln, bad_rng, bad_ro, cur_err;
   logic                  can_pop, push, pop, in_resp;

   assign {cur_we, cur_adr, cur_sel, cur_dat} = cur_q;
   assign idx = cur_adr >> $clog2(SW);
   assign ri = idx[RW-1:0];

   assign bad_aln = (cur_adr & ADDR_WIDTH'(SW - 1)) != '0;
   assign bad_rng = idx >= ADDR_WIDTH'(REGISTER_NUM);

   always_comb begin
      bad_ro = 1'b0;
      rdata = '0;
      if (!bad_rng) begin
         bad_ro = cur_we & RO_MASK[ri];
         rdata = regs_q[ri];
      end
   end

   assign cur_err = bad_aln | bad_rng | bad_ro;

   // The engine takes a new head whenever it is not counting wait states.
   assign can_pop = (state_q != S_WAIT) && (cnt_q != '0);
   assign pop = cyc_i & can_pop;
   assign stall_o = cyc_i & (cnt_q == CW'(FIFO_DEPTH)) & ~can_pop;
   assign push = cyc_i & stb_i & ~stall_o;

   assign in_resp = cyc_i & (state_q == S_RESP);
   assign ack_o = in_resp & ~cur_err;
   assign err_o = in_resp & cur_err;
   assign dat_o = (ack_o & ~cur_we) ? rdata : '0;

   always_comb begin
      state_d = state_q;
      ws_d = ws_q;
      cur_d = cur_q;
      if (!cyc_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_WAIT: begin
               if (ws_q == '0) state_d = S_RESP;
               else ws_d = ws_q - 1'b1;
            end
            default: begin
               state_d = S_IDLE;
               if (can_pop) begin
                  cur_d = mem_q[rd_ptr_q];
                  if (WAIT_STATES > 0) begin
                     state_d = S_WAIT;
                     ws_d = WW'(WAIT_STATES - 1);
                  end else begin
                     state_d = S_RESP;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d = cnt_q;
      if (!cyc_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop) cnt_d = cnt_q + 1'b1;
         else if (pop && !push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (ack_o && cur_we) begin
         for (int b = 0; b < SW; b++) begin
            if (cur_sel[b])
               regs_d[ri][b*GRANULE +: GRANULE] = cur_dat[b*GRANULE +: GRANULE];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         ws_q <= '0;
         cur_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < REGISTER_NUM; i++) regs_q[i] <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         ws_q <= ws_d;
         cur_q <= cur_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q <= cnt_d;
         regs_q <= regs_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= {we_i, adr_i, sel_i, dat_i};
      end
   end
endmodule

// File: tb/tb_wb_regfile_pipe.sv
// Self-checking bench for wb_regfile_pipe: directed vectors, corner
// sequences and random traffic against a timing/content reference model.
module tb_wb_regfile_pipe;
   localparam int D = 4;
   localparam logic [15:0] RO = 16'h0001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cyc_d = 1'b0, stb_d = 1'b0, we_d = 1'b0;
   logic [15:0] adr_d = '0;
   logic [3:0]  sel_d = '0;
   logic [31:0] dat_d = '0;
   int          cur = 0;

   logic c0, s0, c1, s1;
   logic ack0, err0, stl0, ack1, err1, stl1;
   logic [31:0] do0, do1;
   logic ack, err, stall;
   logic [31:0] dat;

   assign c0 = cyc_d & (cur == 0);
   assign s0 = stb_d & (cur == 0);
   assign c1 = cyc_d & (cur == 1);
   assign s1 = stb_d & (cur == 1);
   assign ack = (cur == 1) ? ack1 : ack0;
   assign err = (cur == 1) ? err1 : err0;
   assign stall = (cur == 1) ? stl1 : stl0;
   assign dat = (cur == 1) ? do1 : do0;

   wb_regfile_pipe #(.WAIT_STATES(0), .RO_MASK(RO)) u0 (
      .clk_i(clk), .rst_i(rst_n), .cyc_i(c0), .stb_i(s0),
      .we_i(we_d), .adr_i(adr_d), .sel_i(sel_d), .dat_i(dat_d),
      .dat_o(do0), .ack_o(ack0), .err_o(err0), .stall_o(stl0));

   wb_regfile_pipe #(.WAIT_STATES(2), .RO_MASK(RO)) u1 (
      .clk_i(clk), .rst_i(rst_n), .cyc_i(c1), .stb_i(s1),
      .we_i(we_d), .adr_i(adr_d), .sel_i(sel_d), .dat_i(dat_d),
      .dat_o(do1), .ack_o(ack1), .err_o(err1), .stall_o(stl1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        exp_err;
      logic [31:0] exp_dat;
   } vec_t;

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          pop;
      int          term;
   } req_t;

   // Timing model: a request accepted at edge E is taken by the engine at
   // edge max(E, previous termination)+1 and terminates W cycles later.
   req_t        mq[$];
   req_t        fq[$];
   req_t        pend;
   bit          have_pend;
   bit          rnd;
   int          k, last_term, W;
   int          stall_n;
   int          ack_k[$];
   logic [31:0] mregs [16];

   function automatic bit m_err(input req_t r);
      int idx;
      idx = int'(r.adr) / 4;
      if (int'(r.adr) % 4 != 0) return 1'b1;
      if (idx >= 16) return 1'b1;
      return r.we && RO[idx];
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] v;
      v = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
      return v;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      int u;
      u = int'($urandom_range(0, 19));
      r.we = 1'($urandom_range(0, 1));
      r.sel = 4'($urandom);
      r.dat = $urandom;
      r.pop = 0;
      r.term = 0;
      if (u < 16) r.adr = 16'(u * 4);
      else if (u < 18) r.adr = 16'(64 + 4 * int'($urandom_range(0, 1000)));
      else r.adr = 16'($urandom_range(0, 63) | 1);
      return r;
   endfunction

   function automatic req_t mk(input logic we, input int reg_i,
                               input logic [31:0] d);
      req_t r;
      r.we = we;
      r.adr = 16'(reg_i * 4);
      r.sel = 4'hF;
      r.dat = d;
      r.pop = 0;
      r.term = 0;
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      fq.delete();
      ack_k.delete();
      have_pend = 1'b0;
      k = 1;
      last_term = -100;
      stall_n = 0;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
   endtask

   task automatic tick(input bit do_rst);
      req_t r;
      int   cnt, s;
      bit   popnow, sexp;
      @(negedge clk);
      if (!have_pend) begin
         if (fq.size() > 0) begin
            pend = fq.pop_front();
            have_pend = 1'b1;
         end else if (rnd && $urandom_range(0, 9) < 7) begin
            pend = rand_req();
            have_pend = 1'b1;
         end
      end
      cyc_d = 1'b1;
      stb_d = have_pend;
      we_d = pend.we;
      adr_d = pend.adr;
      sel_d = pend.sel;
      dat_d = pend.dat;
      #1;
      if (mq.size() > 0 && mq[0].term == k - 1) begin
         r = mq.pop_front();
         if (m_err(r)) begin
            chk("resp_err", 32'(err), 1);
            chk("resp_noack", 32'(ack), 0);
            chk("resp_errdat", dat, 0);
         end else begin
            chk("resp_ack", 32'(ack), 1);
            chk("resp_noerr", 32'(err), 0);
            if (!r.we) chk("resp_rdata", dat, mregs[int'(r.adr) / 4]);
            else mregs[int'(r.adr) / 4] = merge(mregs[int'(r.adr) / 4], r.dat, r.sel);
            ack_k.push_back(k - 1);
         end
      end else begin
         chk("idle_ack", 32'(ack), 0);
         chk("idle_err", 32'(err), 0);
         chk("idle_dat", dat, 0);
      end
      cnt = 0;
      popnow = 1'b0;
      foreach (mq[i]) begin
         if (mq[i].pop >= k) cnt++;
         if (mq[i].pop == k) popnow = 1'b1;
      end
      sexp = (cnt == D) && !popnow;
      chk("stall", 32'(stall), 32'(sexp));
      if (sexp && have_pend) stall_n++;
      if (do_rst) begin
         rst_n = 1'b0;
         #1;
         chk("rst_ack", 32'(ack), 0);
         chk("rst_err", 32'(err), 0);
         chk("rst_stall", 32'(stall), 0);
         chk("rst_dat", dat, 0);
         cyc_d = 1'b0;
         stb_d = 1'b0;
         @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         model_reset();
         return;
      end
      @(posedge clk);
      if (have_pend && !sexp) begin
         s = (k > last_term) ? k : last_term;
         pend.pop = s + 1;
         pend.term = s + 1 + W;
         last_term = pend.term;
         mq.push_back(pend);
         have_pend = 1'b0;
      end
      k++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((mq.size() > 0 || have_pend || fq.size() > 0) && n < 300) begin
         tick(1'b0);
         n++;
      end
      chk("drain_done", 32'(mq.size() + fq.size() + int'(have_pend)), 0);
   endtask

   task automatic phase_reset(input int which);
      @(negedge clk);
      cyc_d = 1'b0;
      stb_d = 1'b0;
      rst_n = 1'b0;
      cur = which;
      W = (which == 1) ? 2 : 0;
      @(negedge clk);
      rst_n = 1'b1;
      rnd = 1'b0;
      model_reset();
   endtask

   task automatic single(input vec_t v, output logic a, output logic e,
                         output logic [31:0] d, output int lat);
      @(negedge clk);
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d = v.we;
      adr_d = v.adr;
      sel_d = v.sel;
      dat_d = v.dat;
      #1 chk("tv_stall", 32'(stall), 0);
      @(posedge clk);
      a = 1'b0;
      e = 1'b0;
      d = '0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         stb_d = 1'b0;
         #1;
         if (ack || err) begin
            a = ack;
            e = err;
            d = dat;
            break;
         end
         lat++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   vec_t        tv [10];
   logic        a, e;
   logic [31:0] d;
   int          lat;

   initial begin
      tv[0] = '{1'b0, 16'h000C, 4'h0, 32'h0, 1'b0, 32'h00000000};
      tv[1] = '{1'b1, 16'h0008, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
      tv[2] = '{1'b0, 16'h0008, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF};
      tv[3] = '{1'b1, 16'h0010, 4'hF, 32'h11223344, 1'b0, 32'h0};
      tv[4] = '{1'b1, 16'h0010, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0};
      tv[5] = '{1'b0, 16'h0010, 4'h0, 32'h0, 1'b0, 32'h11BB33DD};
      tv[6] = '{1'b0, 16'h0040, 4'h0, 32'h0, 1'b1, 32'h0};
      tv[7] = '{1'b0, 16'h0002, 4'h0, 32'h0, 1'b1, 32'h0};
      tv[8] = '{1'b1, 16'h0000, 4'hF, 32'h12345678, 1'b1, 32'h0};
      tv[9] = '{1'b0, 16'h0000, 4'h0, 32'h0, 1'b0, 32'h00000000};

      rnd = 1'b0;
      model_reset();
      cur = 0;
      W = 0;
      cyc_d = 1'b1;
      stb_d = 1'b1;
      #21;
      chk("reset_ack", 32'(ack), 0);
      chk("reset_err", 32'(err), 0);
      chk("reset_stall", 32'(stall), 0);
      chk("reset_dat", dat, 0);

      phase_reset(0);
      for (int i = 0; i < 10; i++) begin
         single(tv[i], a, e, d, lat);
         chk($sformatf("tv%0d_ack", i), 32'(a), 32'(!tv[i].exp_err));
         chk($sformatf("tv%0d_err", i), 32'(e), 32'(tv[i].exp_err));
         chk($sformatf("tv%0d_lat", i), lat, 1);
         if (!tv[i].we || tv[i].exp_err)
            chk($sformatf("tv%0d_dat", i), d, tv[i].exp_dat);
      end

      // Backpressure: eight held writes against a 2-wait-state engine.
      phase_reset(1);
      for (int i = 1; i <= 8; i++) fq.push_back(mk(1'b1, i, 32'hC0DE0000 + i));
      drain();
      chk("bp_stall_cycles", stall_n, 3);
      chk("bp_acks", ack_k.size(), 8);
      if (ack_k.size() > 0) chk("bp_first", ack_k[0], 4);
      for (int i = 1; i < ack_k.size(); i++)
         chk($sformatf("bp_space%0d", i), ack_k[i] - ack_k[i-1], 3);
      for (int i = 1; i <= 8; i++) fq.push_back(mk(1'b0, i, 32'h0));
      drain();

      // Abort: drop cyc while the second write is in its response cycle.
      phase_reset(1);
      for (int i = 4; i <= 7; i++) fq.push_back(mk(1'b1, i, 32'hA5A50000 + i));
      while (k <= 7) tick(1'b0);
      @(negedge clk);
      cyc_d = 1'b0;
      stb_d = 1'b0;
      #1;
      chk("abort_ack", 32'(ack), 0);
      chk("abort_err", 32'(err), 0);
      chk("abort_stall", 32'(stall), 0);
      @(posedge clk);
      mq.delete();
      fq.delete();
      have_pend = 1'b0;
      last_term = -100;
      k++;
      repeat (4) tick(1'b0);
      for (int i = 4; i <= 7; i++) fq.push_back(mk(1'b0, i, 32'h0));
      drain();

      // Asynchronous reset while a write is being acknowledged.
      phase_reset(1);
      for (int i = 1; i <= 6; i++) fq.push_back(mk(1'b1, i, 32'h77000000 + i));
      while (k <= 4) tick(1'b0);
      tick(1'b1);
      fq.push_back(mk(1'b0, 1, 32'h0));
      fq.push_back(mk(1'b0, 2, 32'h0));
      drain();

      for (int p = 0; p < 2; p++) begin
         phase_reset(p);
         rnd = 1'b1;
         repeat (300) tick(1'b0);
         rnd = 1'b0;
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
